// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and the 3-bit opcode map.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result, carry/borrow/shift-out and signed overflow.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             Of
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit captures carry-out on add and borrow (A < B) on subtract.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result = '0;
    c      = 1'b0;
    Of     = 1'b0;
    case (s)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        Of     = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        Of     = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_XOR: result = A ^ B;
      OP_NOT: result = ~A;
      OP_SHL: begin
        result = {A[WIDTH-2:0], 1'b0};
        c      = A[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, A[WIDTH-1:1]};
        c      = A[0];
      end
      default: begin
        result = '0;
        c      = 1'b0;
        Of     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, synchronous active-low reset, derived zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       s,
  output logic             c,
  output logic             zero,
  output logic             Of,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             of_d;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .A      (A),
    .B      (B),
    .s      (s),
    .result (res_d),
    .c      (c_d),
    .Of     (of_d)
  );

  // zero is registered alongside out so it reads 0 in reset rather than NOR(0)=1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= '0;
      c    <= 1'b0;
      Of   <= 1'b0;
      zero <= 1'b0;
    end else begin
      out  <= res_d;
      c    <= c_d;
      Of   <= of_d;
      zero <= ~|res_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for alu at WIDTH=8.
module tb_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic [2:0]   s;
  logic         c, zero, Of;
  logic [W-1:0] out;

  typedef struct {
    string        tag;
    logic [W-1:0] out;
    logic         c;
    logic         zero;
    logic         of;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .s     (s),
    .c     (c),
    .zero  (zero),
    .Of    (Of),
    .out   (out)
  );

  function automatic exp_t model(string tag, logic [7:0] a, logic [7:0] b, logic [2:0] op);
    exp_t e;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sbv = $signed(b);
    int r = 0;
    e.tag = tag;
    e.c   = 1'b0;
    e.of  = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; e.c = (r > 255); e.of = (sa + sbv > 127) || (sa + sbv < -128); end
      3'd1: begin r = ua - ub; e.c = (ua < ub); e.of = (sa - sbv > 127) || (sa - sbv < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 255 - ua;
      3'd6: begin r = ua * 2; e.c = (ua >= 128); end
      default: begin r = ua / 2; e.c = (ua % 2 == 1); end
    endcase
    e.out  = r[7:0];
    e.zero = (e.out == 8'h00);
    return e;
  endfunction

  task automatic check(string tag, string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, name, got, exp);
    end
  endtask

  task automatic compare(exp_t e);
    check(e.tag, "out",  out,             e.out);
    check(e.tag, "c",    {{(W-1){1'b0}}, c},    {{(W-1){1'b0}}, e.c});
    check(e.tag, "zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, e.zero});
    check(e.tag, "Of",   {{(W-1){1'b0}}, Of},   {{(W-1){1'b0}}, e.of});
  endtask

  task automatic drive(string tag, logic [7:0] a, logic [7:0] b, logic [2:0] op);
    exp_t e;
    A = a;
    B = b;
    s = op;
    if (rst_n) begin
      e = model(tag, a, b, op);
    end else begin
      e.tag = tag; e.out = '0; e.c = 1'b0; e.zero = 1'b0; e.of = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 1) else begin
      failures++;
      $error("FAIL %s.queue observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() > 0) begin
      last = sb.pop_front();
      compare(last);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    A = '0; B = '0; s = '0;
    @(posedge clk);
    #1;
    drive("reset", 8'hFF, 8'h01, 3'b000);

    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive($sformatf("seq%0d", i), 8'h23, 8'h21, i[2:0]);

    drive("add_wrap",   8'hFF, 8'h01, 3'b000);
    drive("add_ovf",    8'h7F, 8'h01, 3'b000);
    drive("add_zero",   8'h00, 8'h00, 3'b000);
    drive("sub_borrow", 8'h21, 8'h23, 3'b001);
    drive("sub_ovf",    8'h80, 8'h01, 3'b001);
    drive("sub_eq",     8'h55, 8'h55, 3'b001);
    drive("shl",        8'h81, 8'h00, 3'b110);
    drive("shr",        8'h81, 8'h00, 3'b111);
    drive("shr_zero",   8'h01, 8'h00, 3'b111);
    drive("and_zero",   8'hF0, 8'h0F, 3'b010);

    A = 8'hFF; B = 8'h01; s = 3'b000;
    #3;
    last.tag = "hold";
    compare(last);

    drive("mid", 8'h12, 8'h34, 3'b000);
    rst_n = 1'b0;
    drive("mid_rst", 8'hFF, 8'h01, 3'b000);
    rst_n = 1'b1;
    drive("post_rst", 8'h0F, 8'h01, 3'b001);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rop;
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      drive($sformatf("rnd%0d", i), ra, rb, rop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
